// File: rtl/mdu_sequencer.sv
// Multi-cycle unsigned multiply/divide sequencer producing MIPS-style hi/lo.
// Iterates one bit per cycle through an external ALU on the alu_* ports.
module mdu_sequencer #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_data1,
  output logic [31:0] alu_data2,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic [1:0]  alu_compare
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] low_q, low_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] shifted;
  logic        carry;
  logic        lastIter;

  // acc holds P_hi / remainder, low holds P_lo / quotient, opnd holds mcand / dvsr.
  assign shifted  = {acc_q[30:0], low_q[31]};
  assign carry    = (alu_result < alu_data1);
  assign lastIter = (cnt_q == 5'(ITER - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      low_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      low_q   <= low_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    low_d   = low_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start && !mdu_op[1]) begin
          cnt_d = '0;
          if (!mdu_op[0]) begin
            opnd_d  = a;
            acc_d   = '0;
            low_d   = b;
            state_d = MUL;
          end else if (b != 32'd0) begin
            opnd_d  = b;
            acc_d   = '0;
            low_d   = a;
            state_d = DIV;
          end else begin
            hi_d    = a;
            lo_d    = 32'hFFFF_FFFF;
            state_d = DONE;
          end
        end
      end
      MUL: begin
        acc_d = {carry, alu_result[31:1]};
        low_d = {alu_result[0], low_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (lastIter) begin
          hi_d    = acc_d;
          lo_d    = low_d;
          state_d = DONE;
        end
      end
      DIV: begin
        // With the shifted-out top bit set, the wrapped subtract is the true remainder.
        if (acc_q[31] || alu_compare != 2'b01) begin
          acc_d = alu_result;
          low_d = {low_q[30:0], 1'b1};
        end else begin
          acc_d = shifted;
          low_d = {low_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (lastIter) begin
          hi_d    = acc_d;
          lo_d    = low_d;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    alu_data1 = '0;
    alu_data2 = '0;
    alu_op    = 3'b000;
    case (state_q)
      MUL: begin
        busy      = 1'b1;
        alu_data1 = acc_q;
        alu_data2 = low_q[0] ? opnd_q : 32'd0;
      end
      DIV: begin
        busy      = 1'b1;
        alu_op    = 3'b001;
        alu_data1 = shifted;
        alu_data2 = opnd_q;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: a bench-side ALU, a result/latency
// model built on plain 64-bit arithmetic, a per-cycle compare, and directed vectors.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mdu_op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [31:0] alu_data1, alu_data2;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic [1:0]  alu_compare;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  mdu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_compare(alu_compare)
  );

  always #5 clk = ~clk;

  // Dedicated ALU the sequencer drives.
  always_comb begin
    alu_result  = (alu_op == 3'b001) ? alu_data1 - alu_data2 : alu_data1 + alu_data2;
    alu_compare = (alu_data1 == alu_data2) ? 2'b00 : (alu_data1 < alu_data2) ? 2'b01 : 2'b10;
  end

  // Model: cycles until done counts down from 33 (or 1 for divide-by-zero).
  int          rem = 0;
  logic [31:0] expHi = '0, expLo = '0, pendHi = '0, pendLo = '0;
  logic        pendDiv = 1'b0;

  always @(posedge clk) begin
    logic [63:0] prod;
    if (!reset) begin
      rem   <= 0;
      expHi <= '0;
      expLo <= '0;
    end else if (rem == 0) begin
      if (start && !mdu_op[1]) begin
        if (mdu_op[0] && b == 32'd0) begin
          rem   <= 1;
          expHi <= a;
          expLo <= 32'hFFFF_FFFF;
        end else begin
          rem     <= 33;
          pendDiv <= mdu_op[0];
          prod     = 64'(a) * 64'(b);
          pendHi  <= mdu_op[0] ? a % b : prod[63:32];
          pendLo  <= mdu_op[0] ? a / b : prod[31:0];
        end
      end
    end else begin
      rem <= rem - 1;
      if (rem == 2) begin
        expHi <= pendHi;
        expLo <= pendLo;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy", 32'(busy), 32'(rem > 1));
      checkOutput("done", 32'(done), 32'(rem == 1));
      checkOutput("hi", hi, expHi);
      checkOutput("lo", lo, expLo);
      if (rem > 1) begin
        checkOutput("alu_op", 32'(alu_op), pendDiv ? 32'd1 : 32'd0);
      end else begin
        checkOutput("alu_idle", {alu_data1 | alu_data2}, 32'd0);
        checkOutput("alu_op_idle", 32'(alu_op), 32'd0);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1; mdu_op = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called in cycle T+1; reports the cycle (relative to T) that done appears.
  task automatic waitDone(input string name, input int expLat);
    int n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_latency"}, 32'(n), 32'(expLat));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mdu_op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;

    applyStimulus(2'b00, 32'h0001_0000, 32'h0001_0000);
    waitDone("mul_16x16", 33);
    checkOutput("mul_16x16_hi", hi, 32'h0000_0001);
    checkOutput("mul_16x16_lo", lo, 32'h0000_0000);

    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone("mul_max", 33);
    checkOutput("mul_max_hi", hi, 32'hFFFF_FFFE);
    checkOutput("mul_max_lo", lo, 32'h0000_0001);

    applyStimulus(2'b01, 32'd100, 32'd7);
    waitDone("div_100_7", 33);
    checkOutput("div_100_7_hi", hi, 32'd2);
    checkOutput("div_100_7_lo", lo, 32'd14);

    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'h8000_0001);
    waitDone("div_top", 33);
    checkOutput("div_top_hi", hi, 32'h7FFF_FFFE);
    checkOutput("div_top_lo", lo, 32'd1);

    applyStimulus(2'b01, 32'd5, 32'd0);
    waitDone("div_zero", 1);
    checkOutput("div_zero_hi", hi, 32'd5);
    checkOutput("div_zero_lo", lo, 32'hFFFF_FFFF);

    // Start pulse and operand change while busy must be ignored.
    applyStimulus(2'b00, 32'd3, 32'd4);
    repeat (3) @(negedge clk);
    start = 1'b1; mdu_op = 2'b01; a = 32'd99; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    waitDone("mul_3x4", 29);
    checkOutput("mul_3x4_hi", hi, 32'd0);
    checkOutput("mul_3x4_lo", lo, 32'd12);
    repeat (4) @(negedge clk);

    applyStimulus(2'b10, 32'd8, 32'd9);
    repeat (5) @(negedge clk);
    checkOutput("reserved_lo", lo, 32'd12);
    checkOutput("reserved_done", 32'(done), 32'd0);

    applyStimulus(2'b01, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    checkOutput("abort_alu", alu_data1 | alu_data2, 32'd0);
    reset = 1'b1;

    applyStimulus(2'b00, 32'd6, 32'd7);
    waitDone("mul_6x7", 33);
    checkOutput("mul_6x7_hi", hi, 32'd0);
    checkOutput("mul_6x7_lo", lo, 32'd42);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle unsigned multiply/divide unit for the CPU execute stage.
- Acts as the initiator on the ALU port interface: it drives data1/data2/op each cycle and consumes result/compare to iterate.
- Produces MIPS-style hi/lo results behind a start/busy/done handshake.
- Top level instantiates one dedicated ALU and wires it to the alu_* ports.

Parameters:
- ITER, 32, number of iteration cycles; equals the operand width and is fixed at 32.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-low reset; 0 = reset, sampled on the rising edge of clk
- start  input  1  request pulse; accepted only in IDLE
- mdu_op  input  2  00 = multu, 01 = divu; 10 and 11 are reserved
- a  input  32  multiplicand / dividend, sampled when start is accepted
- b  input  32  multiplier / divisor, sampled when start is accepted
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when hi/lo are updated
- hi  output  32  multu: upper product; divu: remainder
- lo  output  32  multu: lower product; divu: quotient
- alu_data1  output  32  ALU operand 1
- alu_data2  output  32  ALU operand 2
- alu_op  output  3  ALU opcode: 000 add, 001 sub
- alu_result  input  32  ALU result, combinational in the same cycle
- alu_compare  input  2  unsigned compare of data1 vs data2: 00 eq, 01 lt, 10 gt

Behaviour:
- Reset (reset=0 at a clock edge): state=IDLE, hi=lo=0, busy=0, done=0, counter=0.
- Reset mid-operation aborts the operation; no done pulse is generated.
- ALU outputs in IDLE and DONE: alu_data1=0, alu_data2=0, alu_op=000.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 with mdu_op=00 → latch mcand=a, P_hi=0, P_lo=b, counter=0; go to MUL.
  - start=1 with mdu_op=01 and b!=0 → latch dvsr=b, R=0, Q=a, counter=0; go to DIV.
  - start=1 with mdu_op=01 and b==0 → hi=a, lo=0xFFFFFFFF; go to DONE.
  - mdu_op=1x → start is ignored; remain in IDLE.
- MUL, each cycle:
  - Drive alu_op=000, alu_data1=P_hi, alu_data2 = P_lo[0] ? mcand : 0.
  - Carry c = (alu_result < alu_data1), computed locally as a 32-bit unsigned compare.
  - Update {P_hi, P_lo} = {c, alu_result, P_lo} >> 1, keeping the low 64 bits.
  - counter++. After the 32nd cycle (counter==31): hi=P_hi, lo=P_lo (post-update values); go to DONE.
- DIV, each cycle:
  - shifted = {R[30:0], Q[31]}, top = R[31].
  - Drive alu_op=001, alu_data1=shifted, alu_data2=dvsr.
  - If top==1 or alu_compare!=01: R=alu_result, Q={Q[30:0],1}. The wrapped 32-bit subtract is correct when top==1.
  - Otherwise: R=shifted, Q={Q[30:0],0}.
  - After 32 cycles: hi=R, lo=Q; go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE. A start arriving in DONE is ignored.
- busy is 1 exactly in MUL and DIV.
- Latency, with start accepted at edge T:
  - Iterations run on cycles T+1..T+32 with busy=1.
  - done=1 and the new hi/lo are visible in cycle T+33.
  - Divide-by-zero: done=1 in cycle T+1; busy never asserts.
- start, a, b and mdu_op are ignored while busy=1. Operands are latched at start, so later changes to a and b have no effect.
- hi/lo hold their last values until the next completed operation. They are never partially updated (internal registers are separate from the hi/lo outputs).
- Back-to-back operation: the earliest next accept is the cycle after DONE, i.e. an operation every 34 cycles.

Test Plan:
- multu a=0x00010000, b=0x00010000, start at T → busy T+1..T+32; done at T+33; hi=0x00000001, lo=0x00000000.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; this exercises the carry path every cycle.
- divu a=100, b=7 → lo=14, hi=2. divu a=0xFFFFFFFF, b=0x80000001 → lo=1, hi=0x7FFFFFFE; this exercises the top-bit path.
- divu a=5, b=0 → done at T+1, busy stays 0; hi=5, lo=0xFFFFFFFF.
- multu 3×4, then pulse start with mdu_op=01 and a change of a at T+5 → result hi=0, lo=12 at T+33; no second operation runs; mdu_op=10 with start → no done and hi/lo unchanged.
- Reset (reset=0) at T+10 during a divu → next cycle busy=0, done=0, hi=lo=0, ALU outputs zero; a fresh multu 6×7 then completes with lo=42, hi=0.
